// File: rtl/sinc_conv_ctrl.sv
// Conversion sequencer for the sinc3 decimation filter.
// Paces filter enables, captures settled results and queues them in a FIFO.
module sinc_conv_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic                  stop_in,
    input  logic [9:0]            osr_in,
    input  logic [15:0]           num_samples_in,
    input  logic [DIV_WIDTH-1:0]  clk_div_in,
    input  logic [1:0]            discard_in,
    output logic                  filt_rst_out,
    output logic                  filt_enable_out,
    output logic [9:0]            filt_osr_out,
    input  logic                  filt_valid_in,
    input  logic [DATA_WIDTH-1:0] filt_data_in,
    output logic                  res_valid_out,
    output logic [DATA_WIDTH-1:0] res_data_out,
    input  logic                  res_ready_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  overflow_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  clr_q, clr_d;
    logic [9:0]            osr_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [15:0]           num_q;
    logic [1:0]            disc_q;
    logic [DIV_WIDTH-1:0]  dcnt_q, dcnt_d;
    logic                  vprev_q;
    logic [1:0]            dsc_cnt_q;
    logic [15:0]           samp_q, samp_inc;
    logic                  ovf_q;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [AW:0]           cnt_q;

    logic load, in_run, cap, drop, push_req;
    logic full, pop, push_ok, complete;

    assign load     = (state_q == IDLE) && start_in;
    assign in_run   = (state_q == RUN);
    assign cap      = in_run && !filt_valid_in && vprev_q;
    assign drop     = cap && (dsc_cnt_q != disc_q);
    assign push_req = cap && !drop;

    assign full     = (cnt_q == FULL_CNT);
    assign pop      = (cnt_q != '0) && res_ready_in;
    assign push_ok  = push_req && (!full || pop);

    assign samp_inc = (samp_q == 16'hFFFF) ? samp_q : samp_q + 16'd1;
    assign complete = push_req && (num_q != 16'd0) && (samp_inc == num_q);

    assign filt_rst_out    = rst || (state_q == CLEAR);
    assign filt_enable_out = in_run && (dcnt_q == '0);
    assign filt_osr_out    = osr_q;
    assign res_valid_out   = (cnt_q != '0);
    assign res_data_out    = mem_q[rptr_q];
    assign busy_out        = (state_q != IDLE);
    assign done_out        = (state_q == DONE);
    assign overflow_out    = ovf_q;

    // Next-state sequencing; a stop always beats a same-cycle completion.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = CLEAR;
                    clr_d   = 1'b0;
                end
            end
            CLEAR: begin
                if (stop_in) state_d = DONE;
                else if (clr_q) state_d = RUN;
                else clr_d = 1'b1;
            end
            RUN: begin
                if (stop_in || complete) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Enable-rate divider: wraps at the latched divide value during RUN.
    always_comb begin
        dcnt_d = '0;
        if (in_run && (dcnt_q != div_q)) dcnt_d = dcnt_q + 1'b1;
    end

    // Control state, latched configuration and capture bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_q     <= 1'b0;
            osr_q     <= '0;
            div_q     <= '0;
            num_q     <= '0;
            disc_q    <= '0;
            dcnt_q    <= '0;
            vprev_q   <= 1'b0;
            dsc_cnt_q <= '0;
            samp_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            dcnt_q  <= dcnt_d;
            vprev_q <= (state_q == CLEAR) ? 1'b0 : filt_valid_in;
            if (load) begin
                osr_q     <= osr_in;
                div_q     <= clk_div_in;
                num_q     <= num_samples_in;
                disc_q    <= discard_in;
                dsc_cnt_q <= '0;
                samp_q    <= '0;
                ovf_q     <= 1'b0;
            end else begin
                if (drop) dsc_cnt_q <= dsc_cnt_q + 2'd1;
                if (push_req) samp_q <= samp_inc;
                if (push_req && !push_ok) ovf_q <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; contents survive across conversions.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= filt_data_in;
    end

endmodule

// File: doc/sinc_conv_ctrl.md
Name: sinc_conv_ctrl

Overview:
- Conversion sequencer for the SAR ADC sinc3 decimation filter.
- Latches a conversion configuration on start and clears the filter.
- Generates the filter's input-enable strobe at a programmable rate, then captures decimated results, discarding the initial settling outputs.
- Queues results in a small FIFO with a valid/ready interface toward the register/readout side, and reports completion and overflow.

Parameters:
- DATA_WIDTH, 32: filter result width.
- FIFO_DEPTH, 4: result FIFO entries; power of 2, at least 2.
- DIV_WIDTH, 8: width of the enable-rate divider.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_in  in  1  pulse; begin conversion (honoured only in IDLE).
- stop_in  in  1  pulse; abort conversion.
- osr_in  in  10  oversample setting; decimation period is osr_in+1 enables.
- num_samples_in  in  16  results to deliver; 0 = continuous until stop.
- clk_div_in  in  DIV_WIDTH  enable issued once every clk_div_in+1 clocks.
- discard_in  in  2  initial filter outputs to drop (0..3).
- filt_rst_out  out  1  filter reset.
- filt_enable_out  out  1  filter input enable.
- filt_osr_out  out  10  filter oversample setting.
- filt_valid_in  in  1  filter data-valid.
- filt_data_in  in  DATA_WIDTH  filter result.
- res_valid_out  out  1  FIFO not empty.
- res_data_out  out  DATA_WIDTH  FIFO head.
- res_ready_in  in  1  consumer accepts head.
- busy_out  out  1  state not IDLE.
- done_out  out  1  one-cycle completion pulse.
- overflow_out  out  1  sticky; a result was dropped because the FIFO was full.

Behaviour:
Reset values:
- filt_rst_out=1 while rst is high. filt_enable_out=0, filt_osr_out=0, res_valid_out=0, busy_out=0, done_out=0, overflow_out=0.
- FIFO empty; all counters 0; state IDLE.

FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE: start_in=1 → CLEAR.
  - Latch osr_in (drives filt_osr_out from the next cycle), clk_div_in, num_samples_in, discard_in.
  - Clear overflow_out.
  - stop_in is ignored in IDLE.
- CLEAR: lasts exactly 2 cycles with filt_rst_out=1, then → RUN.
  - stop_in during CLEAR → DONE.
- RUN: filt_rst_out=0.
  - Divider counts 0..div. filt_enable_out=1 in the cycle the divider equals 0, which is the first RUN cycle.
  - div=0 gives filt_enable_out high every RUN cycle.
  - stop_in=1 → DONE. stop wins over any same-cycle capture or completion; the capture is still pushed.
- DONE: single cycle. done_out=1, filt_enable_out=0 → IDLE.
- filt_enable_out is 0 outside RUN.
- filt_osr_out holds its latched value until the next start.
- start_in in any non-IDLE state is ignored.

Capture:
- A result is captured in RUN only, in the cycle where filt_valid_in=0 and its registered previous value=1 (falling edge).
- The filter's output is stable at that point for both continuous and strobed enables.
- The previous-valid register is forced to 0 in CLEAR.
- The first discard value of captures is dropped.
- Each later capture is pushed into the FIFO and increments the sample counter.
- If the FIFO is full, the value is dropped, overflow_out is set, and the counter still increments.
- When num≠0 and the counter reaches num → DONE on the next cycle. No further enable is issued after the completing capture.

FIFO:
- First-word-fall-through. Pop occurs when res_valid_out and res_ready_in are both high.
- Push and pop in the same cycle while full: both succeed and no overflow is flagged.
- FIFO contents persist across conversions and are cleared only by rst.

Sample counter:
- 16 bits; does not wrap in continuous mode (saturates at 0xFFFF).

Latency:
- Falling edge of filt_valid_in seen → res_valid_out high 1 cycle later (FIFO previously empty).

rst mid-conversion:
- Immediate return to IDLE with all reset values applied; filt_rst_out asserted.

Test Plan:
1. osr_in=15, clk_div_in=0, discard_in=3, num_samples_in=4, filter input held at constant 1, res_ready_in=1 → 4 results each 4096, then done_out pulses once, busy_out falls, filt_enable_out is 0 afterward.
2. Same setup, clk_div_in=2 → filt_enable_out high exactly every 3rd RUN cycle; results identical (4096); total RUN time roughly 3× test 1.
3. FIFO_DEPTH=4, res_ready_in=0, num_samples_in=6, discard_in=0 → 4 entries held, overflow_out=1, done_out pulses. Raise res_ready_in → exactly 4 results drain. Next start clears overflow_out.
4. num_samples_in=0, stop_in after the 5th delivered result → DONE one cycle later, no further captures. start_in asserted while busy → ignored.
5. stop_in the cycle after start_in (during CLEAR) → filt_rst_out high 1–2 cycles, done_out pulses, no filt_enable_out pulse and no results.
6. rst asserted mid-RUN with 2 results queued → next cycle: FIFO empty, res_valid_out=0, busy_out=0, filt_rst_out=1. A new start then runs normally.
